// File: rtl/nibble_sequencer.sv
// nibble_sequencer: fetch/execute sequencer with run/halt/step control for the 4-bit core.
// Optional breakpoint unit is enabled by defining NIBBLE_SEQ_BREAKPOINT_EN.
module nibble_sequencer #(
    parameter int                    PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step_req,
    output logic                step_ack,
    output logic                halted,
    input  logic [7:0]          prog_byte,
    output logic [PC_WIDTH-1:0] pc,
    output logic                phase,
    output logic [3:0]          instr,
    output logic [3:0]          oprnd,
    output logic                c_flag,
    output logic                z_flag,
    input  logic                incPC,
    input  logic                loadPC,
    input  logic                loadFlags,
    input  logic                alu_c,
    input  logic                alu_z,
    output logic                exec_en
`ifdef NIBBLE_SEQ_BREAKPOINT_EN
    ,
    input  logic                bp_valid,
    input  logic [PC_WIDTH-1:0] bp_addr,
    output logic                bp_hit
`endif
);

    typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC} state_t;

    state_t              r_state, w_state_nx;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nx;
    logic [7:0]          r_ir, w_ir_nx;
    logic                r_c, w_c_nx;
    logic                r_z, w_z_nx;
    logic                r_single, w_single_nx;
    logic                r_step_ack, w_step_ack_nx;
    logic                r_bp_hit, w_bp_hit_nx;
    logic [PC_WIDTH-1:0] w_pc_inc, w_jump, w_exec_pc;
    logic                w_run_ok, w_bp_trip;

    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    assign w_jump    = PC_WIDTH'({r_ir[3:0], prog_byte});
    assign w_exec_pc = loadPC ? w_jump : (incPC ? w_pc_inc : r_pc);

`ifdef NIBBLE_SEQ_BREAKPOINT_EN
    assign w_run_ok  = run & ~r_bp_hit;
    assign w_bp_trip = bp_valid && (w_exec_pc == bp_addr);
    assign bp_hit    = r_bp_hit;
`else
    assign w_run_ok  = run;
    assign w_bp_trip = 1'b0;
`endif

    // Next-state, PC, fetch register, flag and handshake logic
    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_ir_nx       = r_ir;
        w_c_nx        = r_c;
        w_z_nx        = r_z;
        w_single_nx   = r_single;
        w_step_ack_nx = 1'b0;
        w_bp_hit_nx   = r_bp_hit;
        case (r_state)
            S_HALT: begin
                if (w_run_ok) begin
                    w_state_nx  = S_FETCH;
                    w_single_nx = 1'b0;
                end else if (step_req) begin
                    w_state_nx  = S_FETCH;
                    w_single_nx = 1'b1;
                    w_bp_hit_nx = 1'b0;
                end
            end
            S_FETCH: begin
                w_ir_nx    = prog_byte;
                w_pc_nx    = incPC ? w_pc_inc : r_pc;
                w_state_nx = S_EXEC;
            end
            S_EXEC: begin
                w_pc_nx = w_exec_pc;
                w_c_nx  = loadFlags ? alu_c : r_c;
                w_z_nx  = loadFlags ? alu_z : r_z;
                if (r_single) begin
                    w_state_nx    = S_HALT;
                    w_step_ack_nx = 1'b1;
                    w_single_nx   = 1'b0;
                end else if (w_bp_trip) begin
                    w_state_nx  = S_HALT;
                    w_bp_hit_nx = 1'b1;
                end else begin
                    w_state_nx = run ? S_FETCH : S_HALT;
                end
            end
            default: w_state_nx = S_HALT;
        endcase
    end

    // State registers; reset may land at any point, including mid-instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_HALT;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_single   <= 1'b0;
            r_step_ack <= 1'b0;
            r_bp_hit   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_ir       <= w_ir_nx;
            r_c        <= w_c_nx;
            r_z        <= w_z_nx;
            r_single   <= w_single_nx;
            r_step_ack <= w_step_ack_nx;
            r_bp_hit   <= w_bp_hit_nx;
        end
    end

    assign pc       = r_pc;
    assign phase    = (r_state == S_EXEC);
    assign halted   = (r_state == S_HALT);
    assign exec_en  = (r_state != S_HALT);
    assign instr    = r_ir[7:4];
    assign oprnd    = r_ir[3:0];
    assign c_flag   = r_c;
    assign z_flag   = r_z;
    assign step_ack = r_step_ack;

endmodule

// File: tb/tb_nibble_sequencer.sv
// tb_nibble_sequencer: directed checks of the sequencer with the bench acting as ROM and decoder.
module tb_nibble_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, run, step_req, step_ack, halted, phase, exec_en;
    logic [7:0]  prog_byte;
    logic [11:0] pc;
    logic [3:0]  instr, oprnd;
    logic        c_flag, z_flag, incPC, loadPC, loadFlags, alu_c, alu_z;
    logic [7:0]  rom [0:4095];
    int          total = 0;
    int          passed = 0;
`ifdef NIBBLE_SEQ_BREAKPOINT_EN
    logic        bp_valid, bp_hit;
    logic [11:0] bp_addr;
`endif

    always #5 clk = ~clk;

    assign prog_byte = rom[pc];

    nibble_sequencer dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step_req(step_req),
        .step_ack(step_ack), .halted(halted), .prog_byte(prog_byte), .pc(pc),
        .phase(phase), .instr(instr), .oprnd(oprnd), .c_flag(c_flag), .z_flag(z_flag),
        .incPC(incPC), .loadPC(loadPC), .loadFlags(loadFlags),
        .alu_c(alu_c), .alu_z(alu_z), .exec_en(exec_en)
`ifdef NIBBLE_SEQ_BREAKPOINT_EN
        , .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clk1(input logic inc, input logic ld, input logic lf);
        incPC = inc;
        loadPC = ld;
        loadFlags = lf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h4A;
        rom[12'h001] = 8'h21;
        rom[12'h002] = 8'h30;
        rom[12'h003] = 8'h80;
        rom[12'h004] = 8'h05;
        rom[12'h005] = 8'h03;
        rom[12'h006] = 8'h7C;
        rom[12'h007] = 8'h8F;
        rom[12'h008] = 8'hFF;
        rom[12'h37C] = 8'h21;
        rom[12'h37D] = 8'h80;
        rom[12'h37E] = 8'h05;
        rom[12'hFFF] = 8'h4A;
        reset_n = 1'b0; run = 1'b0; step_req = 1'b0;
        incPC = 1'b0; loadPC = 1'b0; loadFlags = 1'b0; alu_c = 1'b0; alu_z = 1'b0;
`ifdef NIBBLE_SEQ_BREAKPOINT_EN
        bp_valid = 1'b0; bp_addr = 12'h000;
`endif
        #1;
        check("rst_halted", halted, 1);
        check("rst_pc", pc, 0);
        check("rst_phase", phase, 0);
        check("rst_exec_en", exec_en, 0);
        check("rst_flags", {c_flag, z_flag}, 0);
        check("rst_step_ack", step_ack, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run = 1'b1;
        clk1(0, 0, 0);
        check("lit_fetch_halted", halted, 0);
        check("lit_fetch_phase", phase, 0);
        check("lit_fetch_pc", pc, 0);
        check("lit_fetch_exec_en", exec_en, 1);
        clk1(1, 0, 0);
        check("lit_exec_phase", phase, 1);
        check("lit_exec_pc", pc, 1);
        check("lit_exec_ir", {instr, oprnd}, 8'h4A);
        clk1(0, 0, 0);
        check("lit_next_pc", pc, 1);
        check("lit_next_phase", phase, 0);
        alu_c = 1'b1; alu_z = 1'b0;
        clk1(1, 0, 0);
        clk1(0, 0, 1);
        check("addi_flags", {c_flag, z_flag}, 2'b10);
        check("addi_pc", pc, 2);
        alu_c = 1'b0; alu_z = 1'b1;
        clk1(1, 0, 0);
        clk1(0, 0, 0);
        check("out_flags_held", {c_flag, z_flag}, 2'b10);
        clk1(1, 0, 0);
        clk1(0, 1, 0);
        check("jmp_pc", pc, 12'h005);
        clk1(1, 0, 0);
        check("jc_exec_ir", {instr, oprnd}, 8'h03);
        check("jc_exec_pc", pc, 6);
        clk1(0, 1, 0);
        check("jc_taken_pc", pc, 12'h37C);
        alu_c = 1'b0; alu_z = 1'b1;
        clk1(1, 0, 0);
        clk1(0, 0, 1);
        check("addi2_flags", {c_flag, z_flag}, 2'b01);
        clk1(1, 0, 0);
        clk1(0, 1, 0);
        check("jmp_back_pc", pc, 12'h005);
        clk1(1, 0, 0);
        clk1(1, 0, 0);
        check("jc_not_taken_pc", pc, 12'h007);
        clk1(1, 0, 0);
        clk1(1, 1, 0);
        check("loadpc_wins_pc", pc, 12'hFFF);
        clk1(1, 0, 0);
        check("wrap_pc", pc, 12'h000);
        clk1(0, 0, 0);
        run = 1'b0;
        clk1(1, 0, 0);
        check("rundrop_exec_phase", phase, 1);
        check("rundrop_exec_halted", halted, 0);
        clk1(0, 0, 0);
        check("rundrop_halted", halted, 1);
        check("rundrop_pc", pc, 1);
        check("rundrop_ack", step_ack, 0);
        alu_c = 1'b1; alu_z = 1'b0;
        clk1(1, 1, 1);
        check("halt_hold_pc", pc, 1);
        check("halt_hold_flags", {c_flag, z_flag}, 2'b01);
        check("halt_hold_halted", halted, 1);
        step_req = 1'b1;
        clk1(0, 0, 0);
        step_req = 1'b0;
        check("step_fetch_halted", halted, 0);
        check("step_fetch_ack", step_ack, 0);
        clk1(1, 0, 0);
        check("step_exec_phase", phase, 1);
        clk1(0, 0, 0);
        check("step_done_halted", halted, 1);
        check("step_done_ack", step_ack, 1);
        check("step_done_pc", pc, 2);
        clk1(0, 0, 0);
        check("step_ack_once", step_ack, 0);
        check("step_stay_halted", halted, 1);
        run = 1'b1;
        clk1(0, 0, 0);
        step_req = 1'b1;
        clk1(1, 0, 0);
        clk1(0, 0, 0);
        check("step_running_halted", halted, 0);
        check("step_running_ack", step_ack, 0);
        check("step_running_pc", pc, 3);
        step_req = 1'b0;
        clk1(1, 0, 0);
        check("pre_reset_phase", phase, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 0);
        check("async_rst_flags", {c_flag, z_flag}, 0);
        check("async_rst_halted", halted, 1);
        check("async_rst_exec_en", exec_en, 0);
`ifdef NIBBLE_SEQ_BREAKPOINT_EN
        run = 1'b0;
        rom[12'h003] = 8'h4A;
        bp_valid = 1'b1; bp_addr = 12'h004;
        @(posedge clk); #1;
        reset_n = 1'b1;
        run = 1'b1;
        clk1(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            clk1(1, 0, 0);
            clk1(0, 0, 0);
        end
        check("bp_halted", halted, 1);
        check("bp_pc", pc, 12'h004);
        check("bp_hit_set", bp_hit, 1);
        run = 1'b0;
        clk1(0, 0, 0);
        run = 1'b1;
        clk1(0, 0, 0);
        check("bp_run_ignored", halted, 1);
        check("bp_run_pc", pc, 12'h004);
        step_req = 1'b1;
        clk1(0, 0, 0);
        step_req = 1'b0;
        check("bp_step_clear", bp_hit, 0);
        check("bp_step_fetch", halted, 0);
        clk1(1, 0, 0);
        clk1(0, 0, 0);
        check("bp_step_ack", step_ack, 1);
        check("bp_step_pc", pc, 12'h005);
        check("bp_step_halted", halted, 1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
